// File: rtl/mem_copier.sv
// Byte-wide memory-to-memory copy engine: reads copy_size bytes from src_addr and
// writes them to dst_addr through a single ready-handshaked memory port.
module mem_copier #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] copy_size,
  input  logic              start,
  output logic              finished,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   index_inc;

  assign index_inc = index_q + 1'b1;

  // NOTE: state uses non-blocking assignments so every register updates from
  // pre-edge values; nRST is active-high despite its name.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    count_d   = count_q;
    index_d   = index_q;
    data_d    = data_q;
    finished  = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          count_d = copy_size;
          index_d = '0;
          state_d = (copy_size == '0) ? DONE : READ;
        end
      end
      READ: begin
        mem_ren  = 1'b1;
        mem_addr = src_q + index_q;
        if (mem_ready) begin
          data_d  = mem_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_wen   = 1'b1;
        mem_addr  = dst_q + index_q;
        mem_wdata = data_q;
        if (mem_ready) begin
          index_d = index_inc;
          state_d = (index_inc == count_q) ? DONE : READ;
        end
      end
      DONE: begin
        finished = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copier.sv
// Directed bench for mem_copier: behavioural memory with configurable ready latency,
// a bus monitor, and one task per scenario.
module tb_mem_copier;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] src_addr, dst_addr, copy_size;
  logic       start;
  logic       finished, mem_ren, mem_wen;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ready;

  mem_copier #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .copy_size (copy_size),
    .start     (start),
    .finished  (finished),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: lat extra wait cycles before ready; preload port has priority.
  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  int         lat      = 0;
  int         wait_cnt = 0;
  logic       pl_we    = 1'b0;
  logic [7:0] pl_addr  = '0;
  logic [7:0] pl_data  = '0;

  assign mem_ready = (mem_ren || mem_wen) && (wait_cnt >= lat);
  assign mem_rdata = mem_ren ? mem[mem_addr] : 8'h00;

  always @(posedge CLK) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_wen && mem_ready) mem[mem_addr] <= mem_wdata;
    if ((mem_ren || mem_wen) && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Bus monitor, sampled on the falling edge.
  int          ren_cnt = 0, wen_cnt = 0, fin_cnt = 0, overlap_cnt = 0, unstable_cnt = 0;
  logic        prev_wait = 1'b0;
  logic [17:0] prev_req  = '0;

  always @(negedge CLK) begin
    if (mem_ren && mem_wen) overlap_cnt++;
    if (mem_ren) ren_cnt++;
    if (mem_wen) wen_cnt++;
    if (finished) fin_cnt++;
    if (!nRST && prev_wait && ({mem_ren, mem_wen, mem_addr, mem_wdata} != prev_req))
      unstable_cnt++;
    prev_wait = !nRST && (mem_ren || mem_wen) && !mem_ready;
    prev_req  = {mem_ren, mem_wen, mem_addr, mem_wdata};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    exp_mem[a] = d;
    @(negedge CLK);
    pl_we = 1'b0;
  endtask

  // Reference copy: strictly ascending, byte by byte, with 8-bit wrap.
  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    for (int i = 0; i < int'(n); i++)
      exp_mem[8'(d + 8'(i))] = exp_mem[8'(s + 8'(i))];
  endtask

  function automatic int mem_diff(output logic [7:0] first);
    int cnt = 0;
    first = '0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== exp_mem[i]) begin
        if (cnt == 0) first = 8'(i);
        cnt++;
      end
    return cnt;
  endfunction

  // Start on one edge, then count cycles until finished (cycle 1 follows the start edge).
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                          output int cycles);
    @(negedge CLK);
    src_addr = s; dst_addr = d; copy_size = n; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    cycles = 1;
    while (finished !== 1'b1 && cycles < 3000) begin
      @(negedge CLK);
      cycles++;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; copy_size = '0;
    #1;
    n_checks++;
    if ({finished, mem_ren, mem_wen, mem_addr, mem_wdata} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {finished, mem_ren, mem_wen, mem_addr, mem_wdata});
    end
    repeat (2) @(negedge CLK);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({finished, mem_ren, mem_wen, mem_addr, mem_wdata} !== 19'd0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %b expected all zero",
               {finished, mem_ren, mem_wen, mem_addr, mem_wdata});
    end
    for (int i = 0; i < 256; i++) poke(8'(i), 8'((i * 7 + 3) & 8'hFF));
  endtask

  task automatic test_basic_copy();
    logic [7:0] bytes [8] = '{8'h3C, 8'hA1, 8'h5E, 8'h07, 8'hF2, 8'h99, 8'h10, 8'hCB};
    int cycles, f0, diffs;
    logic [7:0] first;
    for (int i = 0; i < 8; i++) poke(8'(i), bytes[i]);
    f0 = fin_cnt;
    run_copy(8'h00, 8'hF0, 8'd8, cycles);
    model_copy(8'h00, 8'hF0, 8'd8);
    n_checks++;
    if (cycles !== 17) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles expected 17", cycles);
    end
    @(negedge CLK);
    n_checks++;
    if (finished !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse_width: finished still %b, expected 0", finished);
    end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (fin_cnt - f0 !== 1) begin
      n_fail++; $display("FAIL basic_finished_count: got %0d expected 1", fin_cnt - f0);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem[8'hF0 + i] !== bytes[i]) begin
        n_fail++;
        $display("FAIL basic_dst[%0d]: got %h expected %h", i, mem[8'hF0 + i], bytes[i]);
      end
      n_checks++;
      if (mem[i] !== bytes[i]) begin
        n_fail++; $display("FAIL basic_src[%0d]: got %h expected %h", i, mem[i], bytes[i]);
      end
    end
    diffs = mem_diff(first);
    n_checks++;
    if (diffs !== 0) begin
      n_fail++; $display("FAIL basic_memory: %0d bytes differ, first at %h", diffs, first);
    end
  endtask

  task automatic test_zero_size();
    int cycles, r0, w0, diffs;
    logic [7:0] first;
    r0 = ren_cnt; w0 = wen_cnt;
    run_copy(8'h10, 8'h20, 8'd0, cycles);
    n_checks++;
    if (cycles !== 1) begin
      n_fail++; $display("FAIL zero_latency: got %0d cycles expected 1", cycles);
    end
    repeat (3) @(negedge CLK);
    n_checks++;
    if ((ren_cnt - r0) !== 0 || (wen_cnt - w0) !== 0) begin
      n_fail++;
      $display("FAIL zero_no_requests: ren=%0d wen=%0d expected 0/0", ren_cnt - r0, wen_cnt - w0);
    end
    diffs = mem_diff(first);
    n_checks++;
    if (diffs !== 0) begin
      n_fail++; $display("FAIL zero_memory: %0d bytes differ, first at %h", diffs, first);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    int cycles, diffs;
    logic [7:0] first;
    for (int i = 0; i < 8; i++) poke(8'(8'hFC + 8'(i)), bytes[i]);
    run_copy(8'hFC, 8'h80, 8'd8, cycles);
    model_copy(8'hFC, 8'h80, 8'd8);
    n_checks++;
    if (cycles !== 17) begin
      n_fail++; $display("FAIL wrap_latency: got %0d cycles expected 17", cycles);
    end
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem[8'h80 + i] !== bytes[i]) begin
        n_fail++;
        $display("FAIL wrap_src[%0d]: got %h expected %h", i, mem[8'h80 + i], bytes[i]);
      end
    end
    run_copy(8'h80, 8'hFE, 8'd4, cycles);
    model_copy(8'h80, 8'hFE, 8'd4);
    @(negedge CLK);
    n_checks++;
    if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} !== 32'h11223344) begin
      n_fail++;
      $display("FAIL wrap_dst: got %h%h%h%h expected 11223344",
               mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    end
    diffs = mem_diff(first);
    n_checks++;
    if (diffs !== 0) begin
      n_fail++; $display("FAIL wrap_memory: %0d bytes differ, first at %h", diffs, first);
    end
  endtask

  task automatic test_slow_memory();
    int cycles, f0, o0, u0, diffs;
    logic [7:0] first;
    lat = 3;
    f0 = fin_cnt; o0 = overlap_cnt; u0 = unstable_cnt;
    run_copy(8'h50, 8'hD0, 8'd4, cycles);
    model_copy(8'h50, 8'hD0, 8'd4);
    repeat (3) @(negedge CLK);
    lat = 0;
    n_checks++;
    if (cycles !== 33) begin
      n_fail++; $display("FAIL slow_latency: got %0d cycles expected 33", cycles);
    end
    n_checks++;
    if ((unstable_cnt - u0) !== 0) begin
      n_fail++; $display("FAIL slow_stable: %0d request changes while waiting, expected 0",
                         unstable_cnt - u0);
    end
    n_checks++;
    if ((overlap_cnt - o0) !== 0) begin
      n_fail++; $display("FAIL slow_overlap: %0d cycles ren&wen, expected 0", overlap_cnt - o0);
    end
    n_checks++;
    if (fin_cnt - f0 !== 1) begin
      n_fail++; $display("FAIL slow_finished_count: got %0d expected 1", fin_cnt - f0);
    end
    diffs = mem_diff(first);
    n_checks++;
    if (diffs !== 0) begin
      n_fail++; $display("FAIL slow_memory: %0d bytes differ, first at %h", diffs, first);
    end
  endtask

  task automatic test_start_ignored();
    int cycles, f0, diffs;
    logic [7:0] first;
    f0 = fin_cnt;
    @(negedge CLK);
    src_addr = 8'h40; dst_addr = 8'h60; copy_size = 8'd6; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    src_addr = 8'h10; dst_addr = 8'h90; copy_size = 8'd3; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cycles = 5;
    while (finished !== 1'b1 && cycles < 3000) begin
      @(negedge CLK);
      cycles++;
    end
    model_copy(8'h40, 8'h60, 8'd6);
    repeat (4) @(negedge CLK);
    n_checks++;
    if (cycles !== 13) begin
      n_fail++; $display("FAIL ignore_latency: got %0d cycles expected 13", cycles);
    end
    n_checks++;
    if (fin_cnt - f0 !== 1) begin
      n_fail++; $display("FAIL ignore_finished_count: got %0d expected 1", fin_cnt - f0);
    end
    diffs = mem_diff(first);
    n_checks++;
    if (diffs !== 0) begin
      n_fail++; $display("FAIL ignore_memory: %0d bytes differ, first at %h", diffs, first);
    end
    copy_size = 8'd0; src_addr = '0; dst_addr = '0;
  endtask

  task automatic test_reset_abort();
    int cycles, f0, guard, diffs;
    logic [7:0] first;
    logic [7:0] old_b1;
    f0 = fin_cnt;
    old_b1 = exp_mem[8'hB1];
    @(negedge CLK);
    src_addr = 8'h30; dst_addr = 8'hB0; copy_size = 8'd8; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    guard = 0;
    while (!(mem_wen === 1'b1 && mem_addr === 8'hB1) && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    n_checks++;
    if (guard >= 50) begin
      n_fail++; $display("FAIL abort_reach_write: write of byte 2 not seen within 50 cycles");
    end
    #1 nRST = 1'b1;
    #1;
    n_checks++;
    if ({finished, mem_ren, mem_wen, mem_addr, mem_wdata} !== 19'd0) begin
      n_fail++;
      $display("FAIL abort_async_outputs: got %b expected all zero",
               {finished, mem_ren, mem_wen, mem_addr, mem_wdata});
    end
    exp_mem[8'hB0] = exp_mem[8'h30];
    repeat (3) @(negedge CLK);
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (fin_cnt - f0 !== 0) begin
      n_fail++; $display("FAIL abort_no_finished: got %0d pulses expected 0", fin_cnt - f0);
    end
    n_checks++;
    if (mem[8'hB1] !== old_b1) begin
      n_fail++; $display("FAIL abort_byte2_unwritten: got %h expected %h", mem[8'hB1], old_b1);
    end
    diffs = mem_diff(first);
    n_checks++;
    if (diffs !== 0) begin
      n_fail++; $display("FAIL abort_memory: %0d bytes differ, first at %h", diffs, first);
    end
    run_copy(8'h30, 8'hB0, 8'd8, cycles);
    model_copy(8'h30, 8'hB0, 8'd8);
    repeat (2) @(negedge CLK);
    n_checks++;
    if (cycles !== 17) begin
      n_fail++; $display("FAIL restart_latency: got %0d cycles expected 17", cycles);
    end
    diffs = mem_diff(first);
    n_checks++;
    if (diffs !== 0) begin
      n_fail++; $display("FAIL restart_memory: %0d bytes differ, first at %h", diffs, first);
    end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_size();
    test_wrap();
    test_slow_memory();
    test_start_ignored();
    test_reset_abort();
    n_checks++;
    if (overlap_cnt !== 0) begin
      n_fail++; $display("FAIL global_overlap: %0d cycles with ren and wen both high", overlap_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
